stream_demux_1_n: RTL and testbench
===================================

// Module: stream_demux_1_n
// PURPOSE
//  Registered 1:N stream demultiplexer with valid/ready handshake and packet lock.
//  Parametrised successor to the combinational 1:2 DEMUX.
//  Routes each input beat to one of CHANNELS outputs, buffered by one output register stage.
//  The destination is latched at the first beat of a packet and held until the Last beat.
// PARAMETERS
//  DATA_WIDTH  8  width of one data beat
//  CHANNELS    4  number of output channels, legal range 2..16
//  SEL_WIDTH   (localparam) $clog2(CHANNELS), minimum 1
// PORTS
//  Clock_In        in   1                    single clock, rising edge
//  Reset_N_In      in   1                    asynchronous assert, active-low reset
//  Enable_In       in   1                    gates the start of a new packet
//  Select_In       in   SEL_WIDTH            destination channel, sampled on first beat only
//  Data_In         in   DATA_WIDTH           input beat
//  Data_Last_In    in   1                    marks last beat of packet
//  Data_Valid_In   in   1                    input beat valid
//  Data_Ready_Out  out  1                    input beat accepted when Valid & Ready
//  Data_Out        out  DATA_WIDTH           buffered beat, shared by all channels
//  Data_Last_Out   out  1                    buffered Last flag
//  Valid_Out       out  CHANNELS             one-hot valid for the destination channel
//  Ready_In        in   CHANNELS             per-channel sink ready
//  Drop_Count_Out  out  16                   present only with DEMUX_DROP_COUNT_EN
// BEHAVIOUR
//  Reset
//   - Outputs held at 0 while Reset_N_In=0: Data_Out, Data_Last_Out, Valid_Out, Data_Ready_Out.
//   - FSM returns to IDLE, the buffer empties and Drop_Count_Out clears to 0.
//   - Reset mid-packet discards the buffered beat and the packet lock.
//  FSM
//   - IDLE: no packet locked.
//     - A beat is accepted only when Enable_In=1.
//     - On accept, sel_q <= Select_In.
//     - If Data_Last_In=0, go to PKT; otherwise stay in IDLE (single-beat packet).
//   - PKT: Select_In and Enable_In are ignored; beats route to sel_q.
//     - The accepted beat with Data_Last_In=1 returns the FSM to IDLE.
//  Ready
//   - Data_Ready_Out = (state==PKT || Enable_In) && (!buf_v || Ready_In[buf_sel]).
//   - This is pass-through ready, giving 1 beat/cycle sustained throughput.
//  Buffer
//   - Accepted beat appears on Data_Out/Data_Last_Out with Valid_Out[sel] set on the next cycle (latency 1).
//   - buf_v clears when Ready_In[buf_sel]=1 and no new beat is accepted.
//   - A simultaneous drain and accept reloads the buffer the same cycle with no bubble.
//   - Data_Out holds its value while buf_v=0 or the sink stalls; it changes only on accept.
//  Valid_Out
//   - At most one bit set, never for a channel >= CHANNELS.
//   - It stays stable until accepted (AXI-style, no retraction).
//  Enable
//   - Enable_In=0 in IDLE blocks new packets only.
//   - The buffered beat still drains; an open packet still completes.
//  Out-of-range select
//   - Applies when Select_In >= CHANNELS at packet start.
//   - The whole packet is accepted (Data_Ready_Out follows Enable only) and discarded.
//   - No Valid_Out is raised for it.
// CONFIGURATION
//  DEMUX_DROP_COUNT_EN defined
//   - Drop_Count_Out is present.
//   - It increments by 1 per discarded beat and saturates at 16'hFFFF.
//  DEMUX_DROP_COUNT_EN undefined
//   - Port and counter are absent; discard behaviour is unchanged.
// TESTING
//  1. Reset
//     - Stimulus: Reset_N_In=0 mid-packet with buf_v=1.
//     - Required: Valid_Out=0 and Data_Ready_Out=0 immediately.
//     - Required after release: IDLE, and the next packet takes the new Select_In.
//  2. Single beat
//     - Stimulus: Select_In=2, Data_In=8'hA5, Last=1, Ready_In=4'hF.
//     - Required: Valid_Out=4'b0100 and Data_Out=8'hA5 exactly 1 cycle after accept.
//  3. Packet lock
//     - Stimulus: 4-beat packet, Select_In=1, with Select_In changed to 3 on beats 2-4.
//     - Required: all 4 beats on channel 1; Last_Out set only on beat 4.
//  4. Back-pressure
//     - Stimulus: Ready_In[0]=0 for 3 cycles during a channel-0 packet.
//     - Required: Data_Ready_Out=0 while stalled, Data_Out stable.
//     - Required: no beat lost or duplicated; 1 beat/cycle once ready.
//  5. Enable gating
//     - Stimulus: Enable_In=0 in IDLE.
//     - Required: Data_Ready_Out=0.
//     - Stimulus: Enable_In dropped mid-packet.
//     - Required: the packet completes.
//  6. Out-of-range select
//     - Stimulus: CHANNELS=3, Select_In=3, 5-beat packet.
//     - Required: no Valid_Out; Drop_Count_Out=5 with DEMUX_DROP_COUNT_EN.

Source files
------------

// File: rtl/stream_demux_1_n.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux_1_n
//  Purpose  : Registered 1:N stream demultiplexer with valid/ready handshake
//             and packet lock. Each accepted input beat is routed to one of
//             CHANNELS outputs through a single output register stage. The
//             destination is latched on the first beat of a packet and held
//             until the beat carrying Data_Last_In.
//
//  Ports    : Clock_In        - clock, rising edge
//             Reset_N_In      - asynchronous active-low reset
//             Enable_In       - permits the start of a new packet
//             Select_In       - destination, sampled on the first beat only
//             Data_In         - input beat
//             Data_Last_In    - last beat of packet
//             Data_Valid_In   - input beat valid
//             Data_Ready_Out  - input beat accepted when valid & ready
//             Data_Out        - buffered beat, shared by all channels
//             Data_Last_Out   - buffered last flag
//             Valid_Out       - one-hot valid for the destination channel
//             Ready_In        - per-channel sink ready
//             Drop_Count_Out  - saturating count of discarded beats
//                               (present only with DEMUX_DROP_COUNT_EN)
//
//  Options  : `define DEMUX_DROP_COUNT_EN to add the drop counter and port.
//
//  Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1_n #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4
) (
    input  logic                        Clock_In,
    input  logic                        Reset_N_In,
    input  logic                        Enable_In,
    input  logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] Select_In,
    input  logic [DATA_WIDTH-1:0]       Data_In,
    input  logic                        Data_Last_In,
    input  logic                        Data_Valid_In,
    output logic                        Data_Ready_Out,
    output logic [DATA_WIDTH-1:0]       Data_Out,
    output logic                        Data_Last_Out,
    output logic [CHANNELS-1:0]         Valid_Out,
    input  logic [CHANNELS-1:0]         Ready_In
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [15:0]                 Drop_Count_Out
`endif
);

    localparam int c_sel_width = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_pkt  = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [c_sel_width-1:0] r_sel;

    logic                   r_buf_v;
    logic [c_sel_width-1:0] r_buf_sel;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_last;

    logic                   w_gate;
    logic [c_sel_width-1:0] w_route_sel;
    logic                   w_route_oor;
    logic                   w_sink_ready;
    logic                   w_accept;
    logic                   w_load;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept && !Data_Last_In) w_state_next = c_st_pkt;
            c_st_pkt:  if (w_accept &&  Data_Last_In) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. In IDLE the live select steers the first beat; once a
    // packet is open the latched select is used and Enable is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_gate      = 1'b0;
        w_route_sel = r_sel;
        case (r_state)
            c_st_idle: begin
                w_gate      = Enable_In;
                w_route_sel = Select_In;
            end
            c_st_pkt: begin
                w_gate      = 1'b1;
                w_route_sel = r_sel;
            end
            default: begin
                w_gate      = 1'b0;
                w_route_sel = r_sel;
            end
        endcase
    end

    // Destinations that do not exist are swallowed without touching the
    // output buffer, so they must not wait on it either.
    assign w_route_oor  = (32'(w_route_sel) >= 32'(CHANNELS));

    // Only in-range selects are ever loaded, so the one-hot valid vector
    // already identifies the sink whose ready matters.
    assign w_sink_ready = |(Valid_Out & Ready_In);

    assign Data_Ready_Out = Reset_N_In && w_gate &&
                            (w_route_oor || !r_buf_v || w_sink_ready);

    assign w_accept = Data_Valid_In && Data_Ready_Out;
    assign w_load   = w_accept && !w_route_oor;

    // Packet destination latch
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_sel <= '0;
        end else if (w_accept && (r_state == c_st_idle)) begin
            r_sel <= Select_In;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer. A load takes priority over a drain, which gives the
    // bubble-free reload when the sink takes the old beat in the same cycle.
    // Data holds whenever nothing is loaded.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_buf_v   <= 1'b0;
            r_buf_sel <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
        end else if (w_load) begin
            r_buf_v   <= 1'b1;
            r_buf_sel <= w_route_sel;
            r_data    <= Data_In;
            r_last    <= Data_Last_In;
        end else if (r_buf_v && w_sink_ready) begin
            r_buf_v   <= 1'b0;
        end
    end

    assign Data_Out      = r_data;
    assign Data_Last_Out = r_last;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_valid
        assign Valid_Out[i] = r_buf_v && (r_buf_sel == c_sel_width'(i));
    end

`ifdef DEMUX_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_drop_count <= 16'd0;
        end else if (w_accept && w_route_oor && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign Drop_Count_Out = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_demux_1_n
//  Purpose  : Self-checking bench for stream_demux_1_n. A 4-channel instance
//             carries the main traffic, checked through a scoreboard queue;
//             a 3-channel instance exercises the out-of-range select path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_n;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic       en, last_in, valid_in, ready_out, last_out;
    logic [1:0] sel;
    logic [7:0] data_in, data_out;
    logic [3:0] valid_out, ready_in;

    // 3-channel instance
    logic       d3_en, d3_last_in, d3_valid_in, d3_ready_out, d3_last_out;
    logic [1:0] d3_sel;
    logic [7:0] d3_data_in, d3_data_out;
    logic [2:0] d3_valid_out, d3_ready_in;

`ifdef DEMUX_DROP_COUNT_EN
    logic [15:0] drop_cnt, d3_drop_cnt;
`endif

    stream_demux_1_n #(.DATA_WIDTH(8), .CHANNELS(4)) dut (
        .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Select_In(sel),
        .Data_In(data_in), .Data_Last_In(last_in), .Data_Valid_In(valid_in),
        .Data_Ready_Out(ready_out), .Data_Out(data_out), .Data_Last_Out(last_out),
        .Valid_Out(valid_out), .Ready_In(ready_in)
`ifdef DEMUX_DROP_COUNT_EN
        , .Drop_Count_Out(drop_cnt)
`endif
    );

    stream_demux_1_n #(.DATA_WIDTH(8), .CHANNELS(3)) dut3 (
        .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(d3_en), .Select_In(d3_sel),
        .Data_In(d3_data_in), .Data_Last_In(d3_last_in), .Data_Valid_In(d3_valid_in),
        .Data_Ready_Out(d3_ready_out), .Data_Out(d3_data_out), .Data_Last_Out(d3_last_out),
        .Valid_Out(d3_valid_out), .Ready_In(d3_ready_in)
`ifdef DEMUX_DROP_COUNT_EN
        , .Drop_Count_Out(d3_drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t q[$];

    logic [3:0] prev_v;
    logic [7:0] prev_d;
    logic       prev_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v   <= '0;
            prev_d   <= '0;
            prev_acc <= 1'b0;
        end else begin
            if (prev_v != 0 && !prev_acc) begin
                chk("hold_valid", {28'd0, valid_out}, {28'd0, prev_v});
                chk("hold_data", {24'd0, data_out}, {24'd0, prev_d});
            end
            if (valid_out != 0)
                chk("onehot", $countones(valid_out), 1);
            if ((valid_out & ready_in) != 0) begin
                int   ch;
                exp_t e;
                ch = -1;
                for (int i = 0; i < 4; i++) if (valid_out[i]) ch = i;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got beat %0h on ch %0d, required none", data_out, ch);
                end else begin
                    e = q.pop_front();
                    chk("sb_chan", ch, e.ch);
                    chk("sb_data", {24'd0, data_out}, {24'd0, e.data});
                    chk("sb_last", {31'd0, last_out}, {31'd0, e.last});
                end
            end
            prev_v   <= valid_out;
            prev_d   <= data_out;
            prev_acc <= |(valid_out & ready_in);
        end
    end

    // Drive one beat from posedge+1; waits (bounded) for ready, records the
    // expected output, returns at posedge+1 after acceptance.
    task automatic beat(input logic [1:0] s, input logic [7:0] d, input logic l, input int exp_ch);
        int n;
        sel = s; data_in = d; last_in = l; valid_in = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: data %0h never accepted, ready %0b required 1", d, ready_out);
        end else if (exp_ch >= 0) begin
            q.push_back('{exp_ch, d, l});
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // ---------------- single-beat vector table ----------------
    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] exp_valid;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d required 0", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        logic [7:0] held;

        vecs[0] = '{2'd2, 8'hA5, 4'b0100};
        vecs[1] = '{2'd0, 8'h3C, 4'b0001};
        vecs[2] = '{2'd1, 8'h5A, 4'b0010};
        vecs[3] = '{2'd3, 8'hFF, 4'b1000};
        vecs[4] = '{2'd2, 8'h96, 4'b0100};

        rst_n = 1'b0;
        en = 0; sel = 0; data_in = 0; last_in = 0; valid_in = 0; ready_in = 4'hF;
        d3_en = 0; d3_sel = 0; d3_data_in = 0; d3_last_in = 0; d3_valid_in = 0; d3_ready_in = 3'b111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {28'd0, valid_out}, 0);
        chk("rst_data", {24'd0, data_out}, 0);
        chk("rst_last", {31'd0, last_out}, 0);
        chk("rst_ready", {31'd0, ready_out}, 0);
`ifdef DEMUX_DROP_COUNT_EN
        chk("rst_drop", {16'd0, drop_cnt}, 0);
`endif
        @(posedge clk); #1;

        // Reset mid-packet with a stalled buffered beat
        ready_in = 4'h0;
        en = 1'b1;
        beat(2'd1, 8'h11, 1'b0, 1);
        @(negedge clk);
        chk("rst_pre_valid", {28'd0, valid_out}, 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {28'd0, valid_out}, 0);
        chk("rst_mid_ready", {31'd0, ready_out}, 0);
        q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_in = 4'hF;
        beat(2'd3, 8'h33, 1'b1, 3);
        @(negedge clk);
        chk("rst_new_sel", {28'd0, valid_out}, 32'h8);
        @(posedge clk); #1;

        // Single-beat packets, checked one cycle after acceptance
        for (int i = 0; i < 5; i++) begin
            beat(vecs[i].sel, vecs[i].data, 1'b1, int'(vecs[i].sel));
            @(negedge clk);
            chk("tbl_valid", {28'd0, valid_out}, {28'd0, vecs[i].exp_valid});
            chk("tbl_data", {24'd0, data_out}, {24'd0, vecs[i].data});
            chk("tbl_last", {31'd0, last_out}, 1);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_valid", {28'd0, valid_out}, 0);
        chk("idle_data_hold", {24'd0, data_out}, 32'h96);
        @(posedge clk); #1;

        // Packet lock: select changes after first beat are ignored
        beat(2'd1, 8'h41, 1'b0, 1);
        beat(2'd3, 8'h42, 1'b0, 1);
        beat(2'd3, 8'h43, 1'b0, 1);
        beat(2'd3, 8'h44, 1'b1, 1);

        // Back-pressure on channel 0 for three cycles
        fork
            begin
                c0 = cyc;
                for (int i = 0; i < 5; i++)
                    beat(2'd0, 8'hB0 + 8'(i), (i == 4), 0);
                chk("bp_cycles", cyc - c0, 8);
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_in = 4'b1110;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_ready", {31'd0, ready_out}, 0);
                    chk("bp_data", {24'd0, data_out}, 32'hB1);
                    @(posedge clk); #1;
                end
                ready_in = 4'hF;
            end
        join

        // Enable gating
        en = 1'b0; sel = 2'd2; data_in = 8'hEE; last_in = 1'b1; valid_in = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("en_idle_ready", {31'd0, ready_out}, 0);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("en_idle_valid", {28'd0, valid_out}, 0);
        @(posedge clk); #1;
        en = 1'b1;
        beat(2'd2, 8'hC0, 1'b0, 2);
        en = 1'b0;
        beat(2'd2, 8'hC1, 1'b0, 2);
        beat(2'd2, 8'hC2, 1'b1, 2);
        valid_in = 1'b1;
        @(negedge clk);
        chk("en_after_ready", {31'd0, ready_out}, 0);
        @(posedge clk); #1;
        valid_in = 1'b0;

        // Out-of-range select on the 3-channel instance
        d3_en = 1'b1; d3_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            d3_data_in = 8'hD0 + 8'(i); d3_last_in = (i == 4); d3_valid_in = 1'b1;
            @(negedge clk);
            chk("oor_ready", {31'd0, d3_ready_out}, 1);
            chk("oor_valid", {29'd0, d3_valid_out}, 0);
            @(posedge clk); #1;
        end
        d3_valid_in = 1'b0;
        @(negedge clk);
        chk("oor_valid_after", {29'd0, d3_valid_out}, 0);
`ifdef DEMUX_DROP_COUNT_EN
        chk("oor_drop_count", {16'd0, d3_drop_cnt}, 5);
        chk("main_drop_count", {16'd0, drop_cnt}, 0);
`endif
        @(posedge clk); #1;
        d3_sel = 2'd2; d3_data_in = 8'h7E; d3_last_in = 1'b1; d3_valid_in = 1'b1;
        @(negedge clk);
        chk("d3_top_ready", {31'd0, d3_ready_out}, 1);
        @(posedge clk); #1;
        d3_valid_in = 1'b0;
        @(negedge clk);
        chk("d3_top_valid", {29'd0, d3_valid_out}, 32'h4);
        chk("d3_top_data", {24'd0, d3_data_out}, 32'h7E);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
